// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: single-clock FIFO controller around an external simple
// dual-port RAM with a registered read port (dout <= mem[raddr] every edge).
// The registered RAM output is presented as a first-word-fall-through stream.
//
// Optional build macro: FIFO_ERROR_FLAG_EN adds sticky overflow/underflow
// flags and a synchronous error_clear input.
//
// Ports:
//   clk, reset_n               clock (also RAM wclk/rclk), async active-low reset
//   enqueue, enqueue_data      push request and data
//   dequeue                    pop request, honoured only while out_valid
//   out_data, out_valid        FWFT head data (straight from ram_dout) and valid
//   full, empty, count         occupancy status, count in 0..DEPTH
//   ram_waddr, ram_din,
//   ram_write_en, ram_raddr    RAM write/read side controls
//   ram_dout                   registered RAM read data
//   error_clear, overflow,
//   underflow                  only with FIFO_ERROR_FLAG_EN
module ram_fifo_ctrl #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enqueue,
    input  logic [DATA_WIDTH-1:0] enqueue_data,
    input  logic                  dequeue,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_write_en,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
`ifdef FIFO_ERROR_FLAG_EN
    input  logic                  error_clear,
    output logic                  overflow,
    output logic                  underflow,
`endif
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam logic [ADDR_WIDTH:0] DepthCnt = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  out_valid_q, out_valid_d;
    logic                  wr_accept, rd_accept;
    logic [ADDR_WIDTH-1:0] raddr;

    always_comb begin
        full      = (count_q == DepthCnt);
        empty     = (count_q == '0);
        wr_accept = enqueue & ~full;
        rd_accept = dequeue & out_valid_q;

        // Prefetch the next head on a pop so back-to-back pops run every cycle.
        raddr = rd_accept ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;

        wr_ptr_d = wr_accept ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d = rd_accept ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;

        count_d = count_q;
        if (wr_accept && !rd_accept) begin
            count_d = count_q + (ADDR_WIDTH + 1)'(1);
        end else if (rd_accept && !wr_accept) begin
            count_d = count_q - (ADDR_WIDTH + 1)'(1);
        end

        // A write to the address being read this edge returns stale RAM data,
        // so hold valid off one cycle; raddr stays put and the next read is good.
        out_valid_d = (count_d != '0) & ~(wr_accept & (wr_ptr_q == raddr));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        out_data     = ram_dout;
        out_valid    = out_valid_q;
        count        = count_q;
        ram_waddr    = wr_ptr_q;
        ram_din      = enqueue_data;
        ram_write_en = wr_accept;
        ram_raddr    = raddr;
    end

`ifdef FIFO_ERROR_FLAG_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (error_clear) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (enqueue && full) begin
                overflow_q <= 1'b1;
            end
            if (dequeue && !out_valid_q) begin
                underflow_q <= 1'b1;
            end
        end
    end

    always_comb begin
        overflow  = overflow_q;
        underflow = underflow_q;
    end
`endif

endmodule
